sar_scan_ctrl: RTL
==================

# sar_scan_ctrl

Multi-channel scan sequencer for the 8-bit SAR ADC core. Selects an external analog mux channel, waits a programmable settling time, issues start pulses to the SAR core, optionally averages 2^N conversions, and delivers tagged results through a valid/ready handshake. It sits between the SAR core and the result consumer in the top level; the SAR core itself is unchanged.

## Interface
Parameters:
- NCH, 4: number of analog channels (2..8); CW = $clog2(NCH)
- SETTLE_W, 8: width of settle count
- TIMEOUT, 32: max cycles in WAIT before abort

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- en_i  in  1  scan enable (level)
- ch_mask_i  in  NCH  enabled channels, bit i = channel i
- settle_i  in  SETTLE_W  settle cycles after mux change
- avg_i  in  2  log2 of samples averaged per result (0..3 → 1..8)
- mux_sel_o  out  CW  analog mux select
- sar_start_o  out  1  one-cycle start pulse to SAR core
- sar_rdy_i  in  1  SAR conversion done (one-cycle pulse)
- sar_data_i  in  8  SAR result, valid while sar_rdy_i = 1
- res_valid_o  out  1  result valid
- res_ready_i  in  1  consumer accepts result
- res_data_o  out  8  averaged result
- res_ch_o  out  CW  channel of res_data_o
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  sticky timeout flag

## Operation
- States: IDLE, SELECT, SETTLE, START, WAIT, OUTPUT.
- IDLE: if en_i = 1 and ch_mask_i ≠ 0 → SELECT; mux_sel_o loads next channel on that edge. en_i = 1 with mask 0 stays IDLE.
- Next channel: lowest enabled index strictly greater than last-served channel, wrapping to lowest enabled. After reset, last-served = NCH-1, so first channel is lowest enabled index.
- SELECT (1 cycle): latch settle_i and avg_i; clear accumulator and sample count; load settle counter. settle_i = 0 → START, else → SETTLE.
- SETTLE: count settle_i cycles, then → START.
- START (1 cycle): sar_start_o = 1; → WAIT.
- WAIT: on sar_rdy_i, accumulate sar_data_i into 11-bit accumulator. If samples taken < 2^avg → START (no re-settle); else res_data_o ← (acc + sar_data_i) >> avg (truncate), res_ch_o ← mux_sel_o, res_valid_o ← 1, → OUTPUT.
- WAIT timeout: TIMEOUT cycles without sar_rdy_i → err_o ← 1 (sticky until reset), discard channel, mark it served, → IDLE-equivalent next-channel decision (same rules as OUTPUT exit).
- OUTPUT: hold res_valid_o, res_data_o, res_ch_o stable until res_ready_i = 1. On acceptance: res_valid_o ← 0; if en_i = 1 and mask ≠ 0 → SELECT with next channel, else → IDLE.
- en_i deassert mid-channel: current channel completes, including handshake; then IDLE. ch_mask_i changes take effect at next channel decision only.
- sar_rdy_i outside WAIT ignored.

## Timing
- Reset (async): state IDLE, all outputs 0, mux_sel_o = 0, err_o = 0, accumulator 0.
- busy_o = (state ≠ IDLE), combinational from state register.
- SAR core responds to start at cycle t with sar_rdy_i at t+9; per-sample period is 10 cycles (START + 9 WAIT).
- avg = 0, settle S: SELECT cycle 0, START cycle S+1, sar_rdy_i at S+10, res_valid_o high from S+11.
- avg = N adds 10·(2^N − 1) cycles.
- res_ready_i high in the first OUTPUT cycle: SELECT of the next channel on the following cycle.
- Next sar_start_o never earlier than one cycle after the sar_rdy_i cycle.
- Reset mid-operation: immediate return to reset values; pending result lost; SAR core reset from same source by top level.

## Test plan
- Single channel: mask = 4'b0100, settle = 3, avg = 0, SAR model returns 0x5A → mux_sel_o = 2, start at cycle 4, res_valid_o at cycle 14, res_data_o = 0x5A, res_ch_o = 2.
- Round-robin with wrap: mask = 4'b1011, res_ready_i tied 1 → res_ch_o sequence 0,1,3,0,1; mux_sel_o never 2.
- Averaging: avg = 2, SAR returns 10,11,12,14 → four start pulses, no re-settle, res_data_o = 11 (47 >> 2).
- Backpressure: res_ready_i low 20 cycles → res_valid_o, res_data_o stable, no sar_start_o; accept → next SELECT following cycle.
- Timeout: SAR model never asserts rdy → err_o set after 32 WAIT cycles, no res_valid_o, scan moves to next channel; err_o stays 1 until rst_i.
- Reset mid-WAIT and en_i drop: rst_i pulse → all outputs 0 same cycle; en_i low during SETTLE → channel completes, handshake done, then busy_o = 0.

Source files
------------

// File: rtl/sar_scan_ctrl_if.sv
// Handshake bundle between the scan sequencer, the SAR core and the result consumer.
// Signal suffixes are from the sequencer's point of view.
interface sar_scan_ctrl_if #(
  parameter int CW = 2
) ();
  logic          sar_start_o;
  logic          sar_rdy_i;
  logic [7:0]    sar_data_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [7:0]    res_data_o;
  logic [CW-1:0] res_ch_o;

  modport master (
    output sar_start_o, res_valid_o, res_data_o, res_ch_o,
    input  sar_rdy_i, sar_data_i, res_ready_i
  );

  modport slave (
    input  sar_start_o, res_valid_o, res_data_o, res_ch_o,
    output sar_rdy_i, sar_data_i, res_ready_i
  );
endinterface

// File: rtl/sar_scan_ctrl.sv
// Round-robin scan sequencer for the 8-bit SAR core: mux select, settle wait,
// start pulses, 2^N sample averaging, timeout abort and a valid/ready result port.
module sar_scan_ctrl #(
  parameter int NCH      = 4,
  parameter int SETTLE_W = 8,
  parameter int TIMEOUT  = 32,
  localparam int CW      = $clog2(NCH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [NCH-1:0]      ch_mask_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic [1:0]          avg_i,
  output logic [CW-1:0]       mux_sel_o,
  output logic                busy_o,
  output logic                err_o,
  sar_scan_ctrl_if.master     bus_if
);

  localparam int DATA_W = 8;
  localparam int ACC_W  = 11;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       mux_sel_q;
  logic [CW-1:0]       last_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic [1:0]          avg_q;
  logic [ACC_W-1:0]    acc_q;
  logic [3:0]          smp_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                start_q;
  logic                res_valid_q;
  logic [DATA_W-1:0]   res_data_q;
  logic [CW-1:0]       res_ch_q;
  logic                err_q;

  // Lowest enabled channel above 'last', otherwise wrap to the lowest enabled one.
  function automatic logic [CW-1:0] next_chan(input logic [NCH-1:0] mask,
                                              input logic [CW-1:0]  last);
    logic [CW-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) r = CW'(i);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(last))) r = CW'(i);
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum,
                                                  input logic [1:0]       sh);
    logic [ACC_W-1:0] t;
    t = sum >> sh;
    return t[DATA_W-1:0];
  endfunction

  logic             go_d;
  logic [CW-1:0]    first_ch_d;
  logic [CW-1:0]    after_ch_d;
  logic [ACC_W-1:0] acc_d;
  logic [3:0]       smp_d;
  logic             last_smp_d;

  assign go_d       = en_i && (ch_mask_i != '0);
  assign first_ch_d = next_chan(ch_mask_i, last_q);
  assign after_ch_d = next_chan(ch_mask_i, mux_sel_q);
  assign acc_d      = acc_q + ACC_W'(bus_if.sar_data_i);
  assign smp_d      = smp_q + 4'd1;
  assign last_smp_d = smp_d >= (4'd1 << avg_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mux_sel_q   <= '0;
      last_q      <= CW'(NCH - 1);
      cnt_q       <= '0;
      avg_q       <= '0;
      acc_q       <= '0;
      smp_q       <= '0;
      tmo_q       <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_d) begin
            mux_sel_q <= first_ch_d;
            state_q   <= S_SELECT;
          end
        end
        S_SELECT: begin
          acc_q <= '0;
          smp_q <= '0;
          avg_q <= avg_i;
          cnt_q <= settle_i;
          if (settle_i == '0) begin
            start_q <= 1'b1;
            state_q <= S_START;
          end else begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q <= SETTLE_W'(1)) begin
            start_q <= 1'b1;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_q - SETTLE_W'(1);
          end
        end
        S_START: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus_if.sar_rdy_i) begin
            acc_q <= acc_d;
            smp_q <= smp_d;
            if (!last_smp_d) begin
              // Further samples reuse the settled mux; go straight back to START.
              start_q <= 1'b1;
              state_q <= S_START;
            end else begin
              res_data_q  <= avg_trunc(acc_d, avg_q);
              res_ch_q    <= mux_sel_q;
              res_valid_q <= 1'b1;
              state_q     <= S_OUTPUT;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_q  <= 1'b1;
            last_q <= mux_sel_q;
            if (go_d) begin
              mux_sel_q <= after_ch_d;
              state_q   <= S_SELECT;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_OUTPUT: begin
          if (bus_if.res_ready_i) begin
            res_valid_q <= 1'b0;
            last_q      <= mux_sel_q;
            if (go_d) begin
              mux_sel_q <= after_ch_d;
              state_q   <= S_SELECT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mux_sel_o          = mux_sel_q;
  assign busy_o             = (state_q != S_IDLE);
  assign err_o              = err_q;
  assign bus_if.sar_start_o = start_q;
  assign bus_if.res_valid_o = res_valid_q;
  assign bus_if.res_data_o  = res_data_q;
  assign bus_if.res_ch_o    = res_ch_q;

endmodule
